// File: rtl/div_seq.sv
// Sequential unsigned restoring divider with run-time divisor.
// One quotient bit per cycle, MSB first; a zero divisor is flagged instead of iterating.
module div_seq #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [DIV_W-1:0]  divisor,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] q,
  output logic [DIV_W-1:0]  reminder,
  output logic              div_by_zero
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_dividend;
  logic [DIV_W-1:0]    r_divisor;
  logic [DIV_W-1:0]    r_pr;
  logic [DATA_W-2:0]   r_quot;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_dbzPend;
  logic                r_busy;
  logic                r_valid;
  logic [DATA_W-1:0]   r_q;
  logic [DIV_W-1:0]    r_rem;
  logic                r_dbz;

  logic [DIV_W:0]      w_prShift;
  logic [DIV_W:0]      w_diff;
  logic                w_ge;
  logic [DIV_W-1:0]    w_prNext;
  logic [DATA_W-1:0]   w_quotNext;
  logic                w_last;

  // The partial remainder stays below the divisor, so the shifted value is
  // under twice the divisor and the difference's top bit acts as the borrow.
  assign w_prShift  = {r_pr, r_dividend[DATA_W-1]};
  assign w_diff     = w_prShift - {1'b0, r_divisor};
  assign w_ge       = ~w_diff[DIV_W];
  assign w_prNext   = w_ge ? w_diff[DIV_W-1:0] : w_prShift[DIV_W-1:0];
  assign w_quotNext = {r_quot, w_ge};
  assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_pr       <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_dbzPend  <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_q        <= '0;
      r_rem      <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_dbzPend) begin
            r_valid <= 1'b1;
            r_dbz   <= 1'b1;
            r_q     <= '1;
            r_rem   <= '0;
          end
          r_dbzPend <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              r_dbzPend <= 1'b1;
            end else begin
              r_dividend <= data;
              r_divisor  <= divisor;
              r_pr       <= '0;
              r_quot     <= '0;
              r_cnt      <= '0;
              r_busy     <= 1'b1;
              r_state    <= CALC;
            end
          end
        end
        CALC: begin
          r_pr       <= w_prNext;
          r_dividend <= {r_dividend[DATA_W-2:0], 1'b0};
          r_quot     <= w_quotNext[DATA_W-2:0];
          r_cnt      <= r_cnt + 1'b1;
          if (w_last) begin
            r_q     <= w_quotNext;
            r_rem   <= w_prNext;
            r_valid <= 1'b1;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign valid       = r_valid;
  assign q           = r_q;
  assign reminder    = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq with the default 16/4 widths.
module tb_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] data;
  logic [3:0]  divisor;
  logic        busy;
  logic        valid;
  logic [15:0] q;
  logic [3:0]  reminder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;
  int lat;
  int validSeen;

  div_seq #(.DATA_W(16), .DIV_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .data(data),
    .divisor(divisor),
    .busy(busy),
    .valid(valid),
    .q(q),
    .reminder(reminder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start, then scrambles the inputs to show they are latched.
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] v, input logic expBusy);
    data    = d;
    divisor = v;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    data    = 16'hA5A5;
    divisor = 4'h3;
    checkOutput("busy_after_start", {31'b0, busy}, {31'b0, expBusy});
  endtask

  task automatic waitValid(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic checkResult(input string tag, input int expLat, input int gotLat,
                             input logic [15:0] expQ, input logic [3:0] expR, input logic expZ);
    checkOutput({tag, "_lat"}, gotLat, expLat);
    checkOutput({tag, "_q"}, {16'b0, q}, {16'b0, expQ});
    checkOutput({tag, "_rem"}, {28'b0, reminder}, {28'b0, expR});
    checkOutput({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, expZ});
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) checkOutput("busy_valid_excl", {31'b0, busy & valid}, 32'd0);
  end

  int cornerD[4] = '{65535, 65535, 5, 0};
  int cornerV[4] = '{7, 15, 15, 1};
  int cornerQ[4] = '{9362, 4369, 0, 0};
  int cornerR[4] = '{1, 0, 5, 0};

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    data    = '0;
    divisor = '0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_valid", {31'b0, valid}, 32'd0);
    checkOutput("rst_q", {16'b0, q}, 32'd0);
    checkOutput("rst_rem", {28'b0, reminder}, 32'd0);
    checkOutput("rst_dbz", {31'b0, div_by_zero}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_busy", {31'b0, busy}, 32'd0);
    checkOutput("idle_valid", {31'b0, valid}, 32'd0);
    checkOutput("idle_q", {16'b0, q}, 32'd0);

    for (int d = 0; d <= 700; d++) begin
      applyStimulus(d[15:0], 4'd7, 1'b1);
      waitValid(lat);
      checkResult("sweep", 16, lat, 16'(d / 7), 4'(d % 7), 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(cornerD[i][15:0], cornerV[i][3:0], 1'b1);
      waitValid(lat);
      checkResult("corner", 16, lat, cornerQ[i][15:0], cornerR[i][3:0], 1'b0);
    end

    applyStimulus(16'd1000, 4'd0, 1'b0);
    waitValid(lat);
    checkResult("dbz", 1, lat, 16'hFFFF, 4'd0, 1'b1);
    applyStimulus(16'd1000, 4'd7, 1'b1);
    waitValid(lat);
    checkResult("after_dbz", 16, lat, 16'd142, 4'd6, 1'b0);

    applyStimulus(16'd1000, 4'd7, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    data    = 16'd50;
    divisor = 4'd3;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ignored_start_busy", {31'b0, busy}, 32'd1);
    waitValid(lat);
    checkResult("ignored_start", 10, lat, 16'd142, 4'd6, 1'b0);

    applyStimulus(16'd100, 4'd9, 1'b1);
    waitValid(lat);
    checkResult("back_to_back", 16, lat, 16'd11, 4'd1, 1'b0);

    applyStimulus(16'd1000, 4'd7, 1'b1);
    repeat (7) @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_valid", {31'b0, valid}, 32'd0);
    checkOutput("abort_q", {16'b0, q}, 32'd0);
    checkOutput("abort_rem", {28'b0, reminder}, 32'd0);
    checkOutput("abort_dbz", {31'b0, div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    validSeen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid) validSeen++;
    end
    checkOutput("no_stale_valid", validSeen, 32'd0);
    checkOutput("no_stale_busy", {31'b0, busy}, 32'd0);

    applyStimulus(16'd20, 4'd3, 1'b1);
    waitValid(lat);
    checkResult("after_abort", 16, lat, 16'd6, 4'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Parametrised sequential unsigned divider with a run-time divisor. It generalises the fixed divide-by-7 unit: data width and divisor width are parameters, the divisor is an input latched at start, and divide-by-zero is flagged. The start/busy/valid handshake matches the existing divider, so current benches and controllers drive it unchanged.

## Interface
- DATA_W, 16, dividend and quotient width; legal range 2..32.
- DIV_W, 4, divisor and remainder width; legal range 1..DATA_W.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- data  input  DATA_W  dividend; latched on the accepted start edge.
- divisor  input  DIV_W  divisor; latched on the accepted start edge.
- busy  output  1  high while a division is in progress.
- valid  output  1  one-cycle pulse; q, reminder and div_by_zero are valid.
- q  output  DATA_W  quotient = data / divisor.
- reminder  output  DIV_W  remainder = data % divisor.
- div_by_zero  output  1  set with valid when the latched divisor was 0.

## Operation
- States: IDLE, CALC.
- IDLE with start=1 and divisor!=0: latch data and divisor, clear the partial remainder (DIV_W+1 bits) and the bit counter, then go to CALC.
- IDLE with start=1 and divisor==0: stay in IDLE. On the next edge, assert valid and div_by_zero, q = all ones, reminder = 0.
- CALC uses restoring division, one quotient bit per cycle, MSB first:
  - pr = {pr[DIV_W-1:0], dividend MSB};
  - if pr >= divisor: pr = pr - divisor and the quotient bit is 1; otherwise the bit is 0.
  - Exactly DATA_W iterations.
- Last iteration edge: load q and reminder (DIV_W bits of pr), pulse valid, clear div_by_zero, return to IDLE.
- start is ignored while busy=1. data and divisor changes after acceptance have no effect.
- q, reminder and div_by_zero hold their values until the next valid. valid is the only pulse output.
- rst_n low at any time, including mid-CALC: immediately go to IDLE. busy, valid, q, reminder and div_by_zero are 0. The operation in progress is discarded and produces no valid.

## Timing
- Edge E0 samples start in IDLE.
  - Normal case: busy=1 from E0 through the cycle before E_DATA_W. On edge E_DATA_W, valid=1 and busy=0 for one cycle. Latency is DATA_W cycles (16 by default).
  - Divide by zero: busy stays 0. valid=1 from E1 for one cycle. Latency is 1 cycle.
- The valid cycle is an IDLE cycle. A start sampled in that cycle is accepted, giving back-to-back throughput of one result per DATA_W cycles.
- busy and valid are never both 1.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 for 5 cycles -> busy=0, valid=0, q=0, reminder=0, div_by_zero=0. Release rst_n; with start=0, outputs stay at 0.
- Sweep: divisor=7, data 0..700, bench-style handshake (wait !busy, 1-cycle start) -> every q and reminder matches /7 and %7, e.g. 700 gives (100,0). valid arrives exactly 16 cycles after the start edge.
- Corners: 65535/7 -> (9362,1); 65535/15 -> (4369,0); 5/15 -> (0,5); 0/1 -> (0,0).
- Divide by zero: data=1000, divisor=0 -> valid one cycle after start, div_by_zero=1, q=16'hFFFF, reminder=0, busy never high. The next operation, 1000/7, gives (142,6) with div_by_zero=0.
- Handshake:
  - Assert start=1 with data=50 at cycle 5 of a 1000/7 operation -> ignored; the result is still (142,6).
  - Assert start in the valid cycle for 100/9 -> accepted; (11,1) arrives 16 cycles later.
- Reset mid-operation: drop rst_n at cycle 8 of 1000/7 -> all outputs are 0 asynchronously. After release, no valid appears for the aborted operation. A fresh 20/3 gives (6,2).
